hex_entry_display: RTL and testbench

- Downstream consumer of the scan-code-to-hex stage.
- Accepts one 5-bit hex value per strobe (0-15 are valid digits; 16 means a non-hex key) and shifts valid digits into a 4-digit entry register.
- Time-multiplexes the register onto a 4-digit common-anode 7-segment display.
- Reports the entered value, the digit count and a sticky overflow flag.

---
 rtl/hex_entry_display_if.sv | 22 ++
 rtl/hex_entry_display.sv | 109 ++++++++++
 tb/tb_hex_entry_display.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/hex_entry_display_if.sv
// Signal bundle between the scan-code-to-hex stage, the entry/display block and the display pins.
// Strobe semantics: binary is qualified only in a cycle with binary_valid=1; there is no ready, and clr wins over a simultaneous binary_valid.
interface hex_entry_display_if;
    logic [4:0]  binary;
    logic        binary_valid;
    logic        clr;
    logic [15:0] value;
    logic [2:0]  digit_count;
    logic        ovf;
    logic [3:0]  an;
    logic [7:0]  sseg;

    modport master (
        output binary, binary_valid, clr,
        input  value, digit_count, ovf, an, sseg
    );

    modport slave (
        input  binary, binary_valid, clr,
        output value, digit_count, ovf, an, sseg
    );
endinterface

// File: rtl/hex_entry_display.sv
// Four-digit hex entry register with a time-multiplexed common-anode 7-segment driver.
// Valid digits shift in from the right; a sticky flag records any digit pushed out of the left.
module hex_entry_display #(
    parameter int REFRESH_BITS = 18
) (
    input logic                 clk,
    input logic                 reset_n,
    hex_entry_display_if.slave  bus
);

    generate
        if (REFRESH_BITS < 3) begin : g_bad_refresh
            $error("hex_entry_display: REFRESH_BITS must be at least 3");
        end
    endgenerate

    logic [15:0]             value_q, value_d;
    logic [2:0]              count_q, count_d;
    logic                    ovf_q, ovf_d;
    logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
    logic [3:0]              an_q, an_d;
    logic [7:0]              sseg_q, sseg_d;

    logic [1:0]              idx;
    logic [3:0]              nibble;
    logic                    blank;

    function automatic logic [7:0] seg_code(input logic [3:0] hex);
        logic [7:0] code;
        case (hex)
            4'h0: code = 8'hC0;
            4'h1: code = 8'hF9;
            4'h2: code = 8'hA4;
            4'h3: code = 8'hB0;
            4'h4: code = 8'h99;
            4'h5: code = 8'h92;
            4'h6: code = 8'h82;
            4'h7: code = 8'hF8;
            4'h8: code = 8'h80;
            4'h9: code = 8'h90;
            4'hA: code = 8'h88;
            4'hB: code = 8'h83;
            4'hC: code = 8'hC6;
            4'hD: code = 8'hA1;
            4'hE: code = 8'h86;
            default: code = 8'h8E;
        endcase
        return code;
    endfunction

    // Entry register: binary[4] set marks a non-hex key, which leaves all state untouched.
    always_comb begin
        value_d = value_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (bus.clr) begin
            value_d = 16'h0000;
            count_d = 3'd0;
            ovf_d   = 1'b0;
        end else if (bus.binary_valid && !bus.binary[4]) begin
            value_d = {value_q[11:0], bus.binary[3:0]};
            if (count_q == 3'd4) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + 3'd1;
            end
        end
    end

    assign idx       = refresh_q[REFRESH_BITS-1 -: 2];
    assign nibble    = value_q[{idx, 2'b00} +: 4];
    assign refresh_d = refresh_q + {{(REFRESH_BITS-1){1'b0}}, 1'b1};

    // An empty register still lights a "0" on the rightmost digit so the display looks alive.
    assign blank = ({1'b0, idx} >= count_q) && !((count_q == 3'd0) && (idx == 2'd0));

    always_comb begin
        an_d   = ~(4'b0001 << idx);
        sseg_d = blank ? 8'hFF : seg_code(nibble);
        if ((idx == 2'd3) && ovf_q) begin
            sseg_d[7] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q   <= 16'h0000;
            count_q   <= 3'd0;
            ovf_q     <= 1'b0;
            refresh_q <= '0;
            an_q      <= 4'b1111;
            sseg_q    <= 8'hFF;
        end else begin
            value_q   <= value_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            refresh_q <= refresh_d;
            an_q      <= an_d;
            sseg_q    <= sseg_d;
        end
    end

    assign bus.value       = value_q;
    assign bus.digit_count = count_q;
    assign bus.ovf         = ovf_q;
    assign bus.an          = an_q;
    assign bus.sseg        = sseg_q;

endmodule

// File: tb/tb_hex_entry_display.sv
// Randomized bench for hex_entry_display: a digit-list reference model feeds two expected queues
// (entry state and display scan) that monitors pop and compare on the falling clock edge.
module tb_hex_entry_display;

    localparam int RB = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    hex_entry_display_if bus();

    hex_entry_display #(.REFRESH_BITS(RB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned failures = 0;

    logic [3:0]  mdl_digs[$];
    bit          mdl_ovf = 1'b0;
    logic [19:0] exp_q[$];
    logic [11:0] disp_q[$];
    logic [7:0]  seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the list of entered digits, oldest first, at most four kept.
    function automatic logic [19:0] mdl_state();
        int v = 0;
        int n = mdl_digs.size();
        for (int i = 0; i < n; i++) v = v * 16 + int'(mdl_digs[i]);
        return {v[15:0], n[2:0], mdl_ovf};
    endfunction

    function automatic logic [11:0] mdl_disp(input int k);
        int idx = (k >> (RB - 2)) % 4;
        int n = mdl_digs.size();
        logic [3:0] an = 4'hF;
        logic [7:0] seg;
        an[idx] = 1'b0;
        if (idx < n) seg = seg_tbl[mdl_digs[n - 1 - idx]];
        else if (n == 0 && idx == 0) seg = 8'hC0;
        else seg = 8'hFF;
        if (idx == 3 && mdl_ovf) seg[7] = 1'b0;
        return {an, seg};
    endfunction

    function automatic void mdl_apply(input bit v, input logic [4:0] b, input bit c);
        if (c) begin
            mdl_digs.delete();
            mdl_ovf = 1'b0;
        end else if (v && b < 16) begin
            mdl_digs.push_back(b[3:0]);
            if (mdl_digs.size() > 4) begin
                void'(mdl_digs.pop_front());
                mdl_ovf = 1'b1;
            end
        end
    endfunction

    // Display scoreboard producer: k counts active edges since reset release.
    int k = 0;
    always @(posedge clk) begin
        if (!reset_n) begin
            k = 0;
        end else begin
            disp_q.push_back(mdl_disp(k));
            k++;
        end
    end

    // Monitor: compares everything the DUT presents on the falling edge.
    always @(negedge clk) begin
        logic [19:0] e;
        logic [11:0] d;
        if (!reset_n) begin
            disp_q.delete();
            exp_q.delete();
            check("rst_value", {16'h0, bus.value}, 32'h0);
            check("rst_count", {29'h0, bus.digit_count}, 32'h0);
            check("rst_ovf", {31'h0, bus.ovf}, 32'h0);
            check("rst_an", {28'h0, bus.an}, 32'hF);
            check("rst_sseg", {24'h0, bus.sseg}, 32'hFF);
        end else begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("value", {16'h0, bus.value}, {16'h0, e[19:4]});
                check("digit_count", {29'h0, bus.digit_count}, {29'h0, e[3:1]});
                check("ovf", {31'h0, bus.ovf}, {31'h0, e[0]});
            end
            if (disp_q.size() > 0) begin
                d = disp_q.pop_front();
                check("an", {28'h0, bus.an}, {28'h0, d[11:8]});
                check("sseg", {24'h0, bus.sseg}, {24'h0, d[7:0]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic issue(input bit v, input logic [4:0] b, input bit c);
        bus.binary = b;
        bus.binary_valid = v;
        bus.clr = c;
        tick();
        bus.binary_valid = 1'b0;
        bus.clr = 1'b0;
        mdl_apply(v, b, c);
        exp_q.push_back(mdl_state());
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        mdl_digs.delete();
        mdl_ovf = 1'b0;
        tick();
        reset_n = 1'b1;
        exp_q.push_back(mdl_state());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        bus.binary = 5'd0;
        bus.binary_valid = 1'b0;
        bus.clr = 1'b0;
        reset_n = 1'b0;
        idle(3);
        reset_n = 1'b1;
        exp_q.push_back(mdl_state());
        idle(20);

        issue(1'b1, 5'h01, 1'b0);
        issue(1'b1, 5'h02, 1'b0);
        issue(1'b1, 5'h0A, 1'b0);
        issue(1'b1, 5'h0F, 1'b0);
        idle(18);
        issue(1'b1, 5'h03, 1'b0);
        idle(18);
        issue(1'b1, 5'd16, 1'b0);
        issue(1'b1, 5'd31, 1'b0);
        issue(1'b0, 5'd5, 1'b0);
        idle(18);
        issue(1'b1, 5'd7, 1'b1);
        idle(18);
        issue(1'b1, 5'h04, 1'b0);
        issue(1'b1, 5'h09, 1'b0);
        idle(6);
        do_reset();
        idle(18);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3) do_reset();
            else if (r < 10) issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'b1);
            else issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'b0);
            idle($urandom_range(0, 3));
        end
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
